// File: rtl/rr_stream_arbiter_if.sv
// Stream bundle for rr_stream_arbiter: NUM_REQ valid/ready request streams in, one id-tagged stream out.
interface rr_stream_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  localparam int IDW = $clog2(NUM_REQ);

  // Handshake: a beat moves on a rising clk edge where valid and ready are both 1. The source holds
  // valid/data/last stable until that edge; ready may depend on valid, valid never depends on ready.
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_last;
  logic [IDW-1:0]           out_id;

  // master: the environment around the arbiter (requesters plus consumer)
  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_id
  );

  // slave: the arbiter itself
  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, out_id
  );
endinterface

// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output stage; beats are tagged with the source id.
// Optional ARB_PKT_LOCK_EN: hold the grant on one requester from its first beat until its last beat.
module rr_stream_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 32,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_stream_arbiter_if.slave bus,
  output logic [IDW-1:0]  dbg_ptr,
  output logic            dbg_locked
);

  localparam int SW = IDW + 1;

  logic [IDW-1:0]   ptr_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic [IDW-1:0]   out_id_q;

  logic             stage_ready;
  logic             rr_found;
  logic [IDW-1:0]   rr_idx;
  logic [SW-1:0]    scan_idx;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             xfer;
  logic [IDW-1:0]   ptr_next;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

  // The register can take a new beat when empty or when its current beat leaves this cycle.
  assign stage_ready = ~out_valid_q | bus.out_ready;

  // First valid requester scanning ptr, ptr+1, ... with wrap at NUM_REQ.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + SW'(k);
      if (scan_idx >= SW'(NUM_REQ)) begin
        scan_idx = scan_idx - SW'(NUM_REQ);
      end
      if (!rr_found && bus.req_valid[scan_idx[IDW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = scan_idx[IDW-1:0];
      end
    end
  end

`ifdef ARB_PKT_LOCK_EN
  typedef enum logic [0:0] {
    LK_OPEN   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e    lock_state_q, lock_state_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state_q <= LK_OPEN;
      lock_id_q    <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_id_q    <= lock_id_d;
    end
  end

  // While locked only the packet owner competes; others wait even if the owner goes idle.
  always_comb begin
    grant_found = rr_found;
    grant_idx   = rr_idx;
    if (lock_state_q == LK_LOCKED) begin
      grant_found = bus.req_valid[lock_id_q];
      grant_idx   = lock_id_q;
    end
  end

  always_comb begin
    lock_state_d = lock_state_q;
    lock_id_d    = lock_id_q;
    case (lock_state_q)
      LK_OPEN: begin
        if (xfer && !sel_last) begin
          lock_state_d = LK_LOCKED;
          lock_id_d    = grant_idx;
        end
      end
      LK_LOCKED: begin
        if (xfer && sel_last) begin
          lock_state_d = LK_OPEN;
        end
      end
      default: lock_state_d = LK_OPEN;
    endcase
  end

  assign dbg_locked = (lock_state_q == LK_LOCKED);
`else
  assign grant_found = rr_found;
  assign grant_idx   = rr_idx;
  assign dbg_locked  = 1'b0;
`endif

  // Ready is forced low in reset so no requester sees a phantom acceptance.
  assign xfer = rst_n & grant_found & stage_ready;

  always_comb begin
    req_ready_c = '0;
    if (xfer) begin
      req_ready_c[grant_idx] = 1'b1;
    end
  end

  assign sel_data = bus.req_data[grant_idx*WIDTH +: WIDTH];
  assign sel_last = bus.req_last[grant_idx];
  assign ptr_next = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
    end else if (xfer) begin
      ptr_q       <= ptr_next;
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_last_q  <= sel_last;
      out_id_q    <= grant_idx;
    end else if (stage_ready) begin
      // Payload fields keep their old value; only valid drops.
      out_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_id    = out_id_q;
  assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Bench for rr_stream_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_rr_stream_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;
  localparam int BW  = W + IDW + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [IDW-1:0] dbg_ptr;
  logic           dbg_locked;
  int             checks = 0;
  int             failures = 0;

  rr_stream_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  rr_stream_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .dbg_ptr    (dbg_ptr),
    .dbg_locked (dbg_locked)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: pointer, lock owner, output-register occupancy, beats in flight
  int             m_ptr;
  bit             m_lock;
  int             m_lock_id;
  bit             m_ov;
  logic [BW-1:0]  exp_q[$];
  int             seen_id[$];
  bit             seen_last[$];
  logic [N-1:0]   acc;
  logic [N-1:0]   obs_ready;
  logic           obs_ov;
  logic [IDW-1:0] obs_id;
  logic [IDW-1:0] obs_ptr;
  int             seq = 0;

  function automatic void model_reset();
    m_ptr = 0;
    m_lock = 1'b0;
    m_lock_id = 0;
    m_ov = 1'b0;
    exp_q.delete();
    seen_id.delete();
    seen_last.delete();
    acc = '0;
  endfunction

  function automatic int model_grant(input logic [N-1:0] v);
    if (m_lock) return v[m_lock_id] ? m_lock_id : -1;
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // driver tasks
  task automatic drive_beat(input int i, input bit v, input bit last);
    bus.req_valid[i] = v;
    bus.req_last[i] = last;
    bus.req_data[i*W +: W] = {8'hA5, 8'(i), 16'(seq)};
    seq++;
  endtask

  task automatic drive_rand(input int i);
    bus.req_valid[i] = 1'b1;
    bus.req_last[i] = 1'($urandom_range(0, 1));
    bus.req_data[i*W +: W] = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    bus.out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: check DUT against the model at negedge, advance the model, return 1 after posedge.
  task automatic cycle();
    int            g;
    bit            sr;
    logic [N-1:0]  er;
    logic [BW-1:0] got;
    logic [BW-1:0] dropped;
    @(negedge clk);
    obs_ready = bus.req_ready;
    obs_ov = bus.out_valid;
    obs_id = bus.out_id;
    obs_ptr = dbg_ptr;
    checks++;
    if (bus.out_valid !== m_ov) begin
      failures++;
      $display("FAIL out_valid: got %b expected %b", bus.out_valid, m_ov);
    end
    if (m_ov) begin
      got = {bus.out_id, bus.out_last, bus.out_data};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_extra: got %h expected no beat", got);
      end else if (got !== exp_q[0]) begin
        failures++;
        $display("FAIL beat: got %h expected %h", got, exp_q[0]);
      end
      if (bus.out_ready) begin
        if (exp_q.size() != 0) dropped = exp_q.pop_front();
        seen_id.push_back(int'(bus.out_id));
        seen_last.push_back(bus.out_last);
      end
    end
    checks++;
    if (dbg_ptr !== IDW'(m_ptr) || dbg_locked !== m_lock) begin
      failures++;
      $display("FAIL ptr_lock: got ptr=%0d lock=%b expected ptr=%0d lock=%b", dbg_ptr, dbg_locked, m_ptr, m_lock);
    end
    sr = !m_ov || bus.out_ready;
    g = model_grant(bus.req_valid);
    er = '0;
    if (g >= 0 && sr) er[g] = 1'b1;
    checks++;
    if (bus.req_ready !== er) begin
      failures++;
      $display("FAIL req_ready: got %b expected %b", bus.req_ready, er);
    end
    acc = '0;
    if (g >= 0 && sr) begin
      acc[g] = 1'b1;
      exp_q.push_back({IDW'(g), bus.req_last[g], bus.req_data[g*W +: W]});
      m_ptr = (g + 1) % N;
      m_ov = 1'b1;
`ifdef ARB_PKT_LOCK_EN
      m_lock = !bus.req_last[g];
      m_lock_id = g;
`endif
    end else if (sr) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic refill_single();
    for (int i = 0; i < N; i++) begin
      if (acc[i]) drive_beat(i, 1'b1, 1'b1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) drive_beat(i, 1'b1, 1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== '0 || bus.out_valid !== 1'b0 || bus.out_id !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%b ov=%b id=%0d expected 0000 0 0", bus.req_ready, bus.out_valid, bus.out_id);
    end
    checks++;
    if (bus.out_data !== '0 || bus.out_last !== 1'b0 || dbg_ptr !== '0 || dbg_locked !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got data=%h last=%b ptr=%0d lock=%b expected zeros", bus.out_data, bus.out_last, dbg_ptr, dbg_locked);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    checks++;
    if (obs_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant: got %b expected 0001", obs_ready);
    end
    cycle();
    checks++;
    if (obs_ov !== 1'b1 || obs_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_first_beat: got ov=%b id=%0d expected 1 0", obs_ov, obs_id);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) drive_beat(i, 1'b1, 1'b1);
    repeat (9) begin
      cycle();
      refill_single();
    end
    checks++;
    if (seen_id.size() != 8) begin
      failures++;
      $display("FAIL rr_count: got %0d expected 8", seen_id.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (seen_id[k] != k % N) begin
          failures++;
          $display("FAIL rr_order[%0d]: got %0d expected %0d", k, seen_id[k], k % N);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int e_id[3];
    e_id = '{1, 2, 1};
    do_reset();
    drive_beat(1, 1'b1, 1'b1);
    drive_beat(2, 1'b1, 1'b1);
    cycle();
    refill_single();
    bus.out_ready = 1'b0;
    repeat (5) begin
      cycle();
      checks++;
      if (obs_ov !== 1'b1 || obs_id !== 2'd1 || obs_ready !== '0) begin
        failures++;
        $display("FAIL stall_hold: got ov=%b id=%0d ready=%b expected 1 1 0000", obs_ov, obs_id, obs_ready);
      end
      refill_single();
    end
    bus.out_ready = 1'b1;
    cycle();
    refill_single();
    cycle();
    bus.req_valid = '0;
    cycle();
    cycle();
    checks++;
    if (seen_id.size() != 3) begin
      failures++;
      $display("FAIL bp_count: got %0d expected 3", seen_id.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (seen_id[k] != e_id[k]) begin
          failures++;
          $display("FAIL bp_order[%0d]: got %0d expected %0d", k, seen_id[k], e_id[k]);
        end
      end
    end
  endtask

  task automatic test_wrap_sparse();
    do_reset();
    drive_beat(2, 1'b1, 1'b1);
    cycle();
    bus.req_valid = '0;
    cycle();
    checks++;
    if (obs_ptr !== 2'd3) begin
      failures++;
      $display("FAIL wrap_ptr3: got %0d expected 3", obs_ptr);
    end
    drive_beat(0, 1'b1, 1'b1);
    cycle();
    checks++;
    if (obs_ready !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_grant0: got %b expected 0001", obs_ready);
    end
    bus.req_valid = '0;
    cycle();
    checks++;
    if (obs_ptr !== 2'd1) begin
      failures++;
      $display("FAIL wrap_ptr1: got %0d expected 1", obs_ptr);
    end
    drive_beat(3, 1'b1, 1'b1);
    cycle();
    checks++;
    if (obs_ready !== 4'b1000) begin
      failures++;
      $display("FAIL sparse_grant3: got %b expected 1000", obs_ready);
    end
    bus.req_valid = '0;
    cycle();
    checks++;
    if (obs_ptr !== 2'd0) begin
      failures++;
      $display("FAIL sparse_ptr0: got %0d expected 0", obs_ptr);
    end
  endtask

  task automatic test_pkt_lock();
    int e_id[5];
    bit e_last[5];
    int n1;
`ifdef ARB_PKT_LOCK_EN
    e_id = '{1, 1, 1, 2, 0};
    e_last = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
    e_id = '{1, 2, 0, 1, 1};
    e_last = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
    do_reset();
    drive_beat(0, 1'b1, 1'b1);
    cycle();
    bus.req_valid = '0;
    cycle();
    seen_id.delete();
    seen_last.delete();
    drive_beat(0, 1'b1, 1'b1);
    drive_beat(1, 1'b1, 1'b0);
    drive_beat(2, 1'b1, 1'b1);
    n1 = 1;
    repeat (7) begin
      cycle();
      if (acc[1]) begin
        if (n1 < 3) begin
          drive_beat(1, 1'b1, n1 == 2);
          n1++;
        end else begin
          bus.req_valid[1] = 1'b0;
        end
      end
      if (acc[0]) bus.req_valid[0] = 1'b0;
      if (acc[2]) bus.req_valid[2] = 1'b0;
    end
    checks++;
    if (seen_id.size() != 5) begin
      failures++;
      $display("FAIL lock_count: got %0d expected 5", seen_id.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (seen_id[k] != e_id[k] || seen_last[k] != e_last[k]) begin
          failures++;
          $display("FAIL lock_order[%0d]: got id=%0d last=%b expected id=%0d last=%b", k, seen_id[k], seen_last[k], e_id[k], e_last[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    drive_beat(1, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    cycle();
    drive_beat(0, 1'b1, 1'b1);
    drive_beat(1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || dbg_locked !== 1'b0 || dbg_ptr !== '0 || bus.req_ready !== '0) begin
      failures++;
      $display("FAIL midreset_clear: got ov=%b lock=%b ptr=%0d ready=%b expected 0 0 0 0000", bus.out_valid, dbg_locked, dbg_ptr, bus.req_ready);
    end
    model_reset();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    checks++;
    if (obs_ready !== 4'b0001) begin
      failures++;
      $display("FAIL midreset_grant: got %b expected 0001", obs_ready);
    end
    bus.req_valid = '0;
    repeat (2) cycle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) drive_rand(i);
      end
      cycle();
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          if ($urandom_range(0, 2) != 0) drive_rand(i);
          else bus.req_valid[i] = 1'b0;
        end
      end
    end
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    repeat (3) cycle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL random_drain: got %0d beats pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_wrap_sparse();
    test_pkt_lock();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
